// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative multiply/divide unit: operation encodings
// (RISC-V funct3 order), FSM states and operand-signedness helpers.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MULDIV_MUL    = 3'd0,
    MULDIV_MULH   = 3'd1,
    MULDIV_MULHSU = 3'd2,
    MULDIV_MULHU  = 3'd3,
    MULDIV_DIV    = 3'd4,
    MULDIV_DIVU   = 3'd5,
    MULDIV_REM    = 3'd6,
    MULDIV_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } md_state_t;

  function automatic logic op_is_div(input muldiv_op_t op);
    return op[2];
  endfunction

  function automatic logic op_a_signed(input muldiv_op_t op);
    return (op == MULDIV_MUL) || (op == MULDIV_MULH) || (op == MULDIV_MULHSU) ||
           (op == MULDIV_DIV) || (op == MULDIV_REM);
  endfunction

  function automatic logic op_b_signed(input muldiv_op_t op);
    return (op == MULDIV_MUL) || (op == MULDIV_MULH) ||
           (op == MULDIV_DIV) || (op == MULDIV_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Final sign correction and result selection for the multiply/divide unit.
// Purely combinational; operates on the unsigned magnitudes from the datapath.
module muldiv_sign_fix
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  muldiv_op_t          op,
  input  logic                neg_a,
  input  logic                neg_b,
  input  logic                bypass,
  input  logic [XLEN-1:0]     bypass_val,
  input  logic [2*XLEN-1:0]   prod,
  input  logic [XLEN-1:0]     quo,
  input  logic [XLEN-1:0]     rem,
  output logic [XLEN-1:0]     result
);

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;

  always_comb begin
    // Sign flags are already zero for operands treated as unsigned
    prod_s = (neg_a ^ neg_b) ? -prod : prod;
    quo_s  = (neg_a ^ neg_b) ? -quo  : quo;
    rem_s  = neg_a ? -rem : rem;
    result = '0;
    if (bypass) begin
      result = bypass_val;
    end else begin
      case (op)
        MULDIV_MUL:                              result = prod_s[XLEN-1:0];
        MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: result = prod_s[2*XLEN-1:XLEN];
        MULDIV_DIV, MULDIV_DIVU:                 result = quo_s;
        default:                                 result = rem_s;
      endcase
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one bit per cycle, start/done
// handshake, flush cancels in-flight work. Result and tag are registered out of DONE.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t         state_q, state_d;
  muldiv_op_t        op_in, op_q;
  logic [CW-1:0]     cnt_q;
  logic [TAG_W-1:0]  tag_q;
  logic              neg_a_q, neg_b_q, bypass_q;
  logic [XLEN-1:0]   a_mag_q, b_mag_q, quo_q, rem_q, bypass_val_q;
  logic [2*XLEN-1:0] prod_q;

  logic              accept, neg_a_in, neg_b_in, div_zero, div_ovf, special, cnt_last;
  logic [XLEN-1:0]   a_mag_in, b_mag_in, special_val, fixed;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;

  always_comb begin
    op_in    = muldiv_op_t'(op_i);
    accept   = (state_q == ST_IDLE) && start_i && !flush_i;
    neg_a_in = op_a_signed(op_in) && a_i[XLEN-1];
    neg_b_in = op_b_signed(op_in) && b_i[XLEN-1];
    a_mag_in = neg_a_in ? -a_i : a_i;
    b_mag_in = neg_b_in ? -b_i : b_i;
    div_zero = op_is_div(op_in) && (b_i == '0);
    div_ovf  = ((op_in == MULDIV_DIV) || (op_in == MULDIV_REM)) &&
               (a_i == MOST_NEG) && (b_i == '1);
    special  = div_zero || div_ovf;
    // op_i[1] separates REM* from DIV* within the divide group
    if (div_zero) special_val = op_in[1] ? a_i : '1;
    else          special_val = op_in[1] ? '0  : a_i;
    cnt_last = (cnt_q == CW'(XLEN-1));
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_mag_q} : '0);
    div_shift = {rem_q, quo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_mag_q};
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_CALC;
        ST_CALC: if (cnt_last) state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != ST_IDLE);

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .op         (op_q),
    .neg_a      (neg_a_q),
    .neg_b      (neg_b_q),
    .bypass     (bypass_q),
    .bypass_val (bypass_val_q),
    .prod       (prod_q),
    .quo        (quo_q),
    .rem        (rem_q),
    .result     (fixed)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= MULDIV_MUL;
      cnt_q        <= '0;
      tag_q        <= '0;
      neg_a_q      <= 1'b0;
      neg_b_q      <= 1'b0;
      bypass_q     <= 1'b0;
      a_mag_q      <= '0;
      b_mag_q      <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      bypass_val_q <= '0;
      prod_q       <= '0;
      done_o       <= 1'b0;
      result_o     <= '0;
      tag_o        <= '0;
    end else begin
      state_q <= state_d;
      done_o  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q         <= op_in;
            tag_q        <= tag_i;
            neg_a_q      <= neg_a_in;
            neg_b_q      <= neg_b_in;
            a_mag_q      <= a_mag_in;
            b_mag_q      <= b_mag_in;
            bypass_q     <= special;
            bypass_val_q <= special_val;
            cnt_q        <= '0;
            prod_q       <= {{XLEN{1'b0}}, b_mag_in};
            quo_q        <= a_mag_in;
            rem_q        <= '0;
          end
        end
        ST_CALC: begin
          cnt_q <= cnt_last ? '0 : cnt_q + CW'(1);
          if (op_is_div(op_q)) begin
            // Borrow out of the XLEN+1-bit trial subtraction means "restore"
            rem_q <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], ~div_diff[XLEN]};
          end else begin
            prod_q <= {mul_sum, prod_q[XLEN-1:1]};
          end
        end
        default: begin
          done_o   <= 1'b1;
          result_o <= fixed;
          tag_o    <= tag_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed table, multi-cycle
// corner sequences, and random operations against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;
  localparam int NORM_LAT = XLEN + 1;  // edges from accept to the done_o cycle
  localparam int SPEC_LAT = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic [2:0]       op_i;
  logic [XLEN-1:0]  a_i, b_i;
  logic [TAG_W-1:0] tag_i;
  logic             flush_i;
  logic             busy_o, done_o;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] tag_o;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .tag_i    (tag_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .tag_o    (tag_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic following the RISC-V M rules.
  function automatic logic [31:0] model(input muldiv_op_t op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    logic [63:0] ua64 = {32'b0, a};
    logic [63:0] ub64 = {32'b0, b};
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      MULDIV_MUL:    begin p = sa * sb;     return p[31:0];  end
      MULDIV_MULH:   begin p = sa * sb;     return p[63:32]; end
      MULDIV_MULHSU: begin p = sa * ub;     return p[63:32]; end
      MULDIV_MULHU:  begin p = ua64 * ub64; return p[63:32]; end
      MULDIV_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      MULDIV_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MULDIV_REM:    begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default:       return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input muldiv_op_t op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (op[2] && b == 0) return SPEC_LAT;
    if ((op == MULDIV_DIV || op == MULDIV_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return SPEC_LAT;
    return NORM_LAT;
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge of the done_o cycle.
  // After acceptance the inputs are replaced by the "next" values (and start kept
  // high if keep_start) to show the operands are not re-sampled.
  task automatic run_op(input string name, input muldiv_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp, input int exp_lat,
                        input muldiv_op_t nop, input logic [31:0] na,
                        input logic [31:0] nb, input logic keep_start);
    int lat;
    bit seen;
    start_i = 1'b1; op_i = op; a_i = a; b_i = b; tag_i = tag;
    @(posedge clk);
    @(negedge clk);
    chk({name, " busy"}, 64'(busy_o), 64'd1);
    start_i = keep_start; op_i = nop; a_i = na; b_i = nb; tag_i = ~tag;
    lat = 0;
    seen = 0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen = done_o;
    end
    if (!seen) begin
      chk({name, " timeout"}, 64'(lat), 64'(exp_lat));
    end else begin
      chk({name, " latency"}, 64'(lat), 64'(exp_lat));
      chk({name, " result"}, 64'(result_o), 64'(exp));
      chk({name, " tag"}, 64'(tag_o), 64'(tag));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb, ra2, rb2;
    muldiv_op_t  rop;
    int          pick;
    int          dones;

    tbl[0]  = '{MULDIV_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, NORM_LAT};
    tbl[1]  = '{MULDIV_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, NORM_LAT};
    tbl[2]  = '{MULDIV_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, NORM_LAT};
    tbl[3]  = '{MULDIV_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, NORM_LAT};
    tbl[4]  = '{MULDIV_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, NORM_LAT};
    tbl[5]  = '{MULDIV_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, NORM_LAT};
    tbl[6]  = '{MULDIV_DIVU,   32'd100,        32'd7,         32'd14,        NORM_LAT};
    tbl[7]  = '{MULDIV_REMU,   32'd100,        32'd7,         32'd2,         NORM_LAT};
    tbl[8]  = '{MULDIV_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, SPEC_LAT};
    tbl[9]  = '{MULDIV_REM,    32'd5,          32'd0,         32'd5,         SPEC_LAT};
    tbl[10] = '{MULDIV_DIVU,   32'd9,          32'd0,         32'hFFFF_FFFF, SPEC_LAT};
    tbl[11] = '{MULDIV_REMU,   32'd9,          32'd0,         32'd9,         SPEC_LAT};
    tbl[12] = '{MULDIV_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT};
    tbl[13] = '{MULDIV_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         SPEC_LAT};
    tbl[14] = '{MULDIV_MUL,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, NORM_LAT};
    tbl[15] = '{MULDIV_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         NORM_LAT};

    rst = 1'b1; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0; tag_i = '0; flush_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 64'(busy_o), 64'd0);
    chk("reset done", 64'(done_o), 64'd0);
    chk("reset result", 64'(result_o), 64'd0);
    chk("reset tag", 64'(tag_o), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, 5'(i + 3),
             tbl[i].exp, tbl[i].lat, MULDIV_MULHU, $urandom, $urandom, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d pulse", i), 64'(done_o), 64'd0);
      chk($sformatf("vec%0d hold", i), 64'(result_o), 64'(tbl[i].exp));
    end

    // Flush at accept+10 cancels the op; nothing is delivered afterwards.
    start_i = 1'b1; op_i = MULDIV_MUL; a_i = 32'd3; b_i = 32'd5; tag_i = 5'd9;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("flush busy", 64'(busy_o), 64'd0);
    flush_i = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done_o) dones++;
    end
    chk("flush no done", 64'(dones), 64'd0);
    run_op("after flush", MULDIV_DIVU, 32'd1000, 32'd9, 5'd4, 32'd111, NORM_LAT,
           MULDIV_REM, 32'd1, 32'd1, 1'b0);

    // Flush wins over start in the same cycle.
    start_i = 1'b1; flush_i = 1'b1; op_i = MULDIV_MUL;
    @(posedge clk);
    @(negedge clk);
    chk("flush over start", 64'(busy_o), 64'd0);
    start_i = 1'b0; flush_i = 1'b0;

    // start held high: each op accepted on the first idle cycle, 34 edges apart.
    run_op("cont0", MULDIV_MUL, 32'd1234, 32'd5678, 5'd1, 32'd7006652, NORM_LAT,
           MULDIV_DIV, 32'hFFFF_FF00, 32'd16, 1'b1);
    run_op("cont1", MULDIV_DIV, 32'hFFFF_FF00, 32'd16, 5'd2, 32'hFFFF_FFF0, NORM_LAT,
           MULDIV_REMU, 32'd77, 32'd10, 1'b1);
    run_op("cont2", MULDIV_REMU, 32'd77, 32'd10, 5'd3, 32'd7, NORM_LAT,
           MULDIV_MUL, 32'd0, 32'd0, 1'b0);

    for (int i = 0; i < 50; i++) begin
      rop  = muldiv_op_t'(3'($urandom_range(0, 7)));
      pick = $urandom_range(0, 9);
      ra = $urandom; rb = $urandom; ra2 = $urandom; rb2 = $urandom;
      if (pick == 0) rb = 32'd0;
      else if (pick == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (pick == 2) begin ra = ra & 32'hFF; rb = (rb & 32'hF) | 32'd1; end
      run_op($sformatf("rand%0d", i), rop, ra, rb, 5'($urandom), model(rop, ra, rb),
             model_lat(rop, ra, rb), MULDIV_DIV, ra2, rb2, 1'b0);
    end

    // Reset mid-calculation clears every output on the next cycle.
    start_i = 1'b1; op_i = MULDIV_MULHU; a_i = 32'hDEAD_BEEF; b_i = 32'd3; tag_i = 5'd17;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid rst busy", 64'(busy_o), 64'd0);
    chk("mid rst done", 64'(done_o), 64'd0);
    chk("mid rst result", 64'(result_o), 64'd0);
    chk("mid rst tag", 64'(tag_o), 64'd0);
    rst = 1'b0;
    run_op("after rst", MULDIV_MULHU, 32'hDEAD_BEEF, 32'd16, 5'd6, 32'h0000_000D, NORM_LAT,
           MULDIV_MUL, 32'd0, 32'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
